spike_raster_packer: RTL and testbench

- Downstream consumer of the motoneuron-pool spike outputs (MN_bic_spike, MN_tri_spike, and spare channels).
- Turns them into a per-sim-tick raster word stream and feeds the host block-throttled pipe-out endpoint (ep_datain / ep_read / ep_ready).
- Captures spikes from the neuron/sim clock domains and buffers words in a FIFO, all on the host interface clock (ti_clk).
- Reports drops and underflows to the host.

---
 rtl/spike_raster_packer.sv | 105 ++++++++++
 tb/tb_spike_raster_packer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spike_raster_packer.sv
// spike_raster_packer: per-tick spike raster words buffered in a FIFO for a block-throttled pipe-out.
// Define SPIKE_RASTER_PARITY_EN to put even parity in word[15] and narrow seq by one bit.
module spike_raster_packer #(
    parameter int NCH = 8,
    parameter int AW = 10,
    parameter int BLOCK_WORDS = 256
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clear,
    input  logic           capture_en,
    input  logic           sample_tick,
    input  logic [NCH-1:0] spike_in,
    input  logic           ep_read,
    output logic [15:0]    ep_datain,
    output logic           ep_ready,
    output logic [AW:0]    fifo_count,
    output logic [15:0]    overflow_cnt,
    output logic           underflow
);
    localparam int DEPTH = 2 ** AW;
`ifdef SPIKE_RASTER_PARITY_EN
    localparam int SW = 15 - NCH;
`else
    localparam int SW = 16 - NCH;
`endif
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] BLOCK_C = (AW + 1)'(BLOCK_WORDS);

    logic [2:0]     tick_sync;
    logic [NCH-1:0] sp_s1, sp_s2, sp_d, sticky;
    logic [SW-1:0]  seq;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [15:0]    mem [DEPTH];
    logic           tick_pulse, push, pop, accept;
    logic [NCH-1:0] sp_edge, bits;
    logic [15:0]    word;

    assign tick_pulse = tick_sync[1] & ~tick_sync[2];
    assign sp_edge    = sp_s2 & ~sp_d;
    // a spike edge landing on the tick cycle belongs to the current frame
    assign bits       = sticky | sp_edge;
    assign push       = tick_pulse & capture_en & ~clear;
    assign pop        = ep_read & (fifo_count != '0) & ~clear;
    assign accept     = push & ((fifo_count < DEPTH_C) | pop);
`ifdef SPIKE_RASTER_PARITY_EN
    assign word = {^{seq, bits}, seq, bits};
`else
    assign word = {seq, bits};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_sync <= '0;
            sp_s1     <= '0;
            sp_s2     <= '0;
            sp_d      <= '0;
        end else begin
            tick_sync <= {tick_sync[1:0], sample_tick};
            sp_s1     <= spike_in;
            sp_s2     <= sp_s1;
            sp_d      <= sp_s2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky       <= '0;
            seq          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            ep_datain    <= 16'h0000;
            ep_ready     <= 1'b0;
            overflow_cnt <= '0;
            underflow    <= 1'b0;
        end else if (clear) begin
            sticky       <= '0;
            seq          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            ep_datain    <= 16'h0000;
            ep_ready     <= fifo_count >= BLOCK_C;
            overflow_cnt <= '0;
            underflow    <= 1'b0;
        end else begin
            sticky     <= (!capture_en || tick_pulse) ? '0 : bits;
            seq        <= push ? seq + 1'b1 : seq;
            wr_ptr     <= accept ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
            fifo_count <= fifo_count + (AW + 1)'(accept) - (AW + 1)'(pop);
            ep_ready   <= fifo_count >= BLOCK_C;
            if (push && !accept && overflow_cnt != 16'hFFFF)
                overflow_cnt <= overflow_cnt + 1'b1;
            if (ep_read) begin
                ep_datain <= pop ? mem[rd_ptr] : 16'hFFFF;
                underflow <= underflow | ~pop;
            end
        end
    end

    always_ff @(posedge clk)
        if (accept) mem[wr_ptr] <= word;
endmodule

// File: tb/tb_spike_raster_packer.sv
// tb_spike_raster_packer: random spike frames checked against a queue-based FIFO model.
module tb_spike_raster_packer;
    localparam int NCH = 8;
    localparam int AW = 4;
    localparam int BW = 8;
    localparam int DEPTH = 2 ** AW;
`ifdef SPIKE_RASTER_PARITY_EN
    localparam int SW = 15 - NCH;
    localparam logic [15:0] PAR_WORD = 16'h8001;
`else
    localparam int SW = 16 - NCH;
    localparam logic [15:0] PAR_WORD = 16'h0001;
`endif

    logic clk = 0, reset_n = 0, clear = 0, capture_en = 0, sample_tick = 0, ep_read = 0;
    logic [NCH-1:0] spike_in = '0;
    logic [15:0] ep_datain, overflow_cnt;
    logic ep_ready, underflow;
    logic [AW:0] fifo_count;

    spike_raster_packer #(.NCH(NCH), .AW(AW), .BLOCK_WORDS(BW)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .capture_en(capture_en),
        .sample_tick(sample_tick), .spike_in(spike_in), .ep_read(ep_read),
        .ep_datain(ep_datain), .ep_ready(ep_ready), .fifo_count(fifo_count),
        .overflow_cnt(overflow_cnt), .underflow(underflow));

    always #5 clk = ~clk;

    logic [15:0] q[$];
    int seq_m = 0, ovf_m = 0;
    logic uf_m = 0;
    logic [15:0] dat_m = 16'h0000;
    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int s, input logic [NCH-1:0] m);
        logic [15:0] w;
        w = 16'(((s % (1 << SW)) << NCH) | int'(m));
`ifdef SPIKE_RASTER_PARITY_EN
        w[15] = ^w[14:0];
`endif
        return w;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_pop;
        if (q.size() == 0) begin
            dat_m = 16'hFFFF;
            uf_m = 1'b1;
        end else dat_m = q.pop_front();
    endtask

    task automatic model_tick(input logic [NCH-1:0] m);
        if (capture_en) begin
            if (q.size() < DEPTH) q.push_back(mk(seq_m, m));
            else if (ovf_m < 16'hFFFF) ovf_m++;
            seq_m++;
        end
    endtask

    task automatic frame(input logic [NCH-1:0] m, input logic coinc, input logic rd);
        logic [NCH-1:0] all;
        all = m | (coinc ? NCH'(2) : NCH'(0));
        if (m != '0) begin
            spike_in = m;
            cyc(3);
            spike_in = '0;
            cyc(3);
        end
        sample_tick = 1'b1;
        if (coinc) spike_in[1] = 1'b1;
        cyc(2);
        ep_read = rd;
        cyc(1);
        ep_read = 1'b0;
        if (rd) begin
            model_pop();
            check("sim_pop_data", ep_datain, dat_m);
        end
        model_tick(all);
        cyc(3);
        sample_tick = 1'b0;
        spike_in = '0;
        cyc(3);
    endtask

    task automatic rd;
        ep_read = 1'b1;
        cyc(1);
        ep_read = 1'b0;
        model_pop();
        check("rd_data", ep_datain, dat_m);
        check("rd_count", fifo_count, q.size());
    endtask

    task automatic status(input string tag);
        cyc(1);
        check({tag, "_count"}, fifo_count, q.size());
        check({tag, "_ovf"}, overflow_cnt, ovf_m);
        check({tag, "_uf"}, underflow, uf_m);
        check({tag, "_ready"}, ep_ready, q.size() >= BW);
    endtask

    task automatic do_clear;
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        q.delete();
        seq_m = 0;
        ovf_m = 0;
        uf_m = 1'b0;
        dat_m = 16'h0000;
        check("clear_data", ep_datain, 16'h0000);
    endtask

    initial begin
        cyc(3);
        reset_n = 1'b1;
        cyc(2);
        check("rst_data", ep_datain, 16'h0000);
        status("rst");

        frame(NCH'(3), 1'b0, 1'b0);
        status("cap_off");

        capture_en = 1'b1;
        frame(NCH'(9), 1'b0, 1'b0);
        status("single");
        rd();
        check("single_word", ep_datain, 16'h0009);
        cyc(2);
        check("hold_data", ep_datain, dat_m);

        frame('0, 1'b1, 1'b0);
        frame('0, 1'b0, 1'b0);
        rd();
        rd();
        status("coinc");

        for (int i = 0; i < BW; i++) begin
            frame(NCH'($urandom), 1'b0, 1'b0);
            status("thr");
        end
        for (int i = 0; i < BW; i++) rd();
        status("drain");

        frame(NCH'($urandom), 1'b0, 1'b0);
        do_clear();
        status("clear");

        for (int i = 0; i < 20; i++) frame(NCH'($urandom), 1'b0, 1'b0);
        status("ovf");
        frame(NCH'($urandom), 1'b0, 1'b1);
        status("full_sim");
        for (int i = 0; i < DEPTH; i++) rd();
        rd();
        status("under");
        frame(NCH'($urandom), 1'b0, 1'b1);
        status("empty_sim");
        rd();

        do_clear();
        frame(NCH'(1), 1'b0, 1'b0);
        rd();
        check("parity_word", ep_datain, PAR_WORD);

        for (int i = 0; i < 3; i++) frame(NCH'($urandom), 1'b0, 1'b0);
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        q.delete();
        seq_m = 0;
        ovf_m = 0;
        uf_m = 1'b0;
        check("midrst_data", ep_datain, 16'h0000);
        status("midrst");
        frame(NCH'($urandom), 1'b0, 1'b0);
        rd();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
